btb_update: RTL

//  Write side of the 2-bit branch predictor: owns the BTB/BHT table and writes
//  it on branch resolution from EX. Exposes tag/valid/target/counter for the

---
 rtl/btb_update_if.sv | 39 +++
 rtl/btb_update.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_if.sv
// ----------------------------------------------------------------------------
// btb_upd_if
// Resolved-branch update bus from EX into the BTB/BHT write side.
//   valid   : update request
//   ready   : table side can take the update this cycle
//   pc      : PC of the resolved instruction
//   is_br   : instruction is a branch/jump
//   taken   : actual direction
//   target  : actual target address
// master = EX stage (request side), slave = btb_update (table side).
// ----------------------------------------------------------------------------
interface btb_upd_if #(
    parameter int ADDR_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic              is_br;
    logic              taken;
    logic [ADDR_W-1:0] target;

    modport master (
        output valid,
        output pc,
        output is_br,
        output taken,
        output target,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  is_br,
        input  taken,
        input  target,
        output ready
    );
endinterface

// File: rtl/btb_update.sv
// ----------------------------------------------------------------------------
// btb_update
// Write side of a 2-bit branch predictor. Owns the BTB/BHT table
// (entry = {valid, tag, target, ctr}) and updates it when EX resolves a
// branch. The fetch PC reads tag/valid/target/counter MSB combinationally.
// A table-wide invalidate sweep runs after reset and on every flush.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rd_pc_i           fetch PC for lookup
//   rd_tag_o          stored tag at index(rd_pc_i)
//   rd_flag_br_o      entry valid, held low while sweeping
//   rd_target_o       stored target
//   rd_taken_o        counter MSB (predict taken)
//   upd               update bus (slave side of btb_upd_if)
//   flush_i           request full table invalidate
//   busy_o            invalidate sweep in progress
// ----------------------------------------------------------------------------
module btb_update #(
    parameter int IDX_W  = 8,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_pc_i,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              rd_flag_br_o,
    output logic [ADDR_W-1:0] rd_target_o,
    output logic              rd_taken_o,
    btb_upd_if.slave          upd,
    input  logic              flush_i,
    output logic              busy_o
);
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Saturating 2-bit counter helpers
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        sat_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        sat_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   sweep_idx_r, sweep_idx_s;

    logic               tbl_valid_r  [DEPTH];
    logic [TAG_W-1:0]   tbl_tag_r    [DEPTH];
    logic [ADDR_W-1:0]  tbl_target_r [DEPTH];
    logic [1:0]         tbl_ctr_r    [DEPTH];

    logic               stg_valid_r;
    logic [IDX_W-1:0]   stg_idx_r;
    logic [TAG_W-1:0]   stg_tag_r;
    logic               stg_is_br_r;
    logic               stg_taken_r;
    logic [ADDR_W-1:0]  stg_target_r;

    logic               accept_s;
    logic [IDX_W-1:0]   rd_idx_s;
    logic               hit_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               wr_valid_s;
    logic [TAG_W-1:0]   wr_tag_s;
    logic [ADDR_W-1:0]  wr_target_s;
    logic [1:0]         wr_ctr_s;
    logic               unused_pc_bits_s;

    // Only the index/tag fields of either PC matter to the table
    assign unused_pc_bits_s = ^{rd_pc_i[ADDR_W-1:IDX_W+2], rd_pc_i[1:0],
                                upd.pc[ADDR_W-1:IDX_W+TAG_W+2], upd.pc[1:0]};

    // Flush wins over a same-cycle update request
    assign upd.ready = (state_r == ST_RUN) && !flush_i;
    assign accept_s  = upd.valid && upd.ready;
    assign busy_o    = (state_r == ST_SWEEP);

    // Combinational read port; a same-cycle write is seen only after the edge
    assign rd_idx_s     = rd_pc_i[IDX_W+1:2];
    assign rd_tag_o     = tbl_tag_r[rd_idx_s];
    assign rd_target_o  = tbl_target_r[rd_idx_s];
    assign rd_taken_o   = tbl_ctr_r[rd_idx_s][1];
    assign rd_flag_br_o = tbl_valid_r[rd_idx_s] && !busy_o;

    // State and sweep index register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_SWEEP;
            sweep_idx_r <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_s;
            sweep_idx_r <= sweep_idx_s;
        end
    end

    // Next-state logic: sweep every index once, restart it on flush
    always_comb begin
        state_s     = state_r;
        sweep_idx_s = sweep_idx_r;
        case (state_r)
            ST_SWEEP: begin
                if (flush_i) begin
                    sweep_idx_s = {IDX_W{1'b0}};
                end else if (sweep_idx_r == {IDX_W{1'b1}}) begin
                    state_s     = ST_RUN;
                    sweep_idx_s = {IDX_W{1'b0}};
                end else begin
                    sweep_idx_s = sweep_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_s     = ST_SWEEP;
                    sweep_idx_s = {IDX_W{1'b0}};
                end else begin
                    state_s     = ST_RUN;
                end
            end
            default: begin
                state_s     = ST_SWEEP;
                sweep_idx_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Stage register between acceptance and the read-modify-write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_valid_r  <= 1'b0;
            stg_idx_r    <= {IDX_W{1'b0}};
            stg_tag_r    <= {TAG_W{1'b0}};
            stg_is_br_r  <= 1'b0;
            stg_taken_r  <= 1'b0;
            stg_target_r <= {ADDR_W{1'b0}};
        end else begin
            stg_valid_r <= accept_s;
            if (accept_s) begin
                stg_idx_r    <= upd.pc[IDX_W+1:2];
                stg_tag_r    <= upd.pc[IDX_W+TAG_W+1:IDX_W+2];
                stg_is_br_r  <= upd.is_br;
                stg_taken_r  <= upd.taken;
                stg_target_r <= upd.target;
            end else begin
                stg_idx_r    <= stg_idx_r;
                stg_tag_r    <= stg_tag_r;
                stg_is_br_r  <= stg_is_br_r;
                stg_taken_r  <= stg_taken_r;
                stg_target_r <= stg_target_r;
            end
        end
    end

    assign hit_s = tbl_valid_r[stg_idx_r] && (tbl_tag_r[stg_idx_r] == stg_tag_r);

    // Table write selection: sweep clear or staged RMW (a flush kills the RMW)
    always_comb begin
        wr_en_s     = 1'b0;
        wr_idx_s    = stg_idx_r;
        wr_valid_s  = tbl_valid_r[stg_idx_r];
        wr_tag_s    = tbl_tag_r[stg_idx_r];
        wr_target_s = tbl_target_r[stg_idx_r];
        wr_ctr_s    = tbl_ctr_r[stg_idx_r];
        if (state_r == ST_SWEEP) begin
            wr_en_s     = 1'b1;
            wr_idx_s    = sweep_idx_r;
            wr_valid_s  = 1'b0;
            wr_tag_s    = tbl_tag_r[sweep_idx_r];
            wr_target_s = tbl_target_r[sweep_idx_r];
            wr_ctr_s    = 2'b01;
        end else if (stg_valid_r && stg_is_br_r && !flush_i) begin
            if (hit_s) begin
                wr_en_s = 1'b1;
                if (stg_taken_r) begin
                    wr_ctr_s    = sat_inc(tbl_ctr_r[stg_idx_r]);
                    wr_target_s = stg_target_r;
                end else begin
                    wr_ctr_s    = sat_dec(tbl_ctr_r[stg_idx_r]);
                end
            end else if (stg_taken_r) begin
                wr_en_s     = 1'b1;
                wr_valid_s  = 1'b1;
                wr_tag_s    = stg_tag_r;
                wr_target_s = stg_target_r;
                wr_ctr_s    = 2'b10;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage; contents are defined by the sweep, not by reset
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            tbl_valid_r[wr_idx_s]  <= wr_valid_s;
            tbl_tag_r[wr_idx_s]    <= wr_tag_s;
            tbl_target_r[wr_idx_s] <= wr_target_s;
            tbl_ctr_r[wr_idx_s]    <= wr_ctr_s;
        end
    end
endmodule
